dmux_stream_router: RTL and testbench

DMUX_STREAM_ROUTER -- requirements
Module: dmux_stream_router

---
 rtl/dmux_pkg.sv | 18 +
 rtl/dmux_decode.sv | 27 ++
 rtl/dmux_stream_router.sv | 79 +++++++
 tb/tb_dmux_stream_router.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmux_pkg.sv
// Shared definitions for the stream demultiplexer: select-width helper and
// the two-state stage encoding.
package dmux_pkg;

  // Stage register occupancy: EMPTY holds nothing, HOLD offers a beat.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // Width of a binary channel index; never narrower than one bit.
  function automatic int sel_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dmux_decode.sv
// Binary-to-one-hot channel decoder with an out-of-range flag for
// select values that name a channel that does not exist.
module dmux_decode
  import dmux_pkg::*;
#(
  parameter int N = 8,
  localparam int SELW = sel_width(N)
) (
  input  logic [SELW-1:0] sel,
  output logic [N-1:0]    onehot,
  output logic            oor
);

  // Set the bit matching sel; no match means the index is out of range.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    onehot = '0;
    oor    = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (sel == SELW'(i)) begin
        onehot[i] = 1'b1;
        oor       = 1'b0;
      end
    end
  end

endmodule

// File: rtl/dmux_stream_router.sv
// One-beat stream demultiplexer. A beat is held in a stage register with a
// per-channel pending mask; unicast targets one channel, broadcast targets
// all, and each channel drains its own bit independently. A new beat can be
// loaded in the same cycle the last pending bit clears.
module dmux_stream_router
  import dmux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 8,
  localparam int SELW = sel_width(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SELW-1:0]  in_sel,
  input  logic             in_bcast,
  output logic [N-1:0]     out_valid,
  input  logic [N-1:0]     out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             err_drop
);

  state_t           state;
  logic [N-1:0]     pending;
  logic [WIDTH-1:0] data;

  logic             full;
  logic [N-1:0]     remaining;
  logic [N-1:0]     uni_mask;
  logic             sel_oor;
  logic             accept;
  logic             load;
  logic             drop;

  dmux_decode #(.N(N)) u_decode (
    .sel    (in_sel),
    .onehot (uni_mask),
    .oor    (sel_oor)
  );

  // Handshake bookkeeping; out_ready may reach in_ready, but nothing on the
  // input side reaches the outputs except through the stage register.
  always_comb begin
    full      = (state == ST_HOLD);
    remaining = pending & ~out_ready;
    in_ready  = !full || (remaining == '0);
    accept    = in_valid && in_ready;
    load      = accept && (in_bcast || !sel_oor);
    drop      = accept && !in_bcast && sel_oor;
    out_valid = full ? pending : '0;
    out_data  = data;
  end

  // Stage register: load a new beat, otherwise retire handshaken channels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      pending  <= '0;
      data     <= '0;
      err_drop <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      err_drop <= drop;
      if (load) begin
        state   <= ST_HOLD;
        pending <= in_bcast ? {N{1'b1}} : uni_mask;
        data    <= in_data;
      end else if (full) begin
        pending <= remaining;
        if (remaining == '0) begin
          state <= ST_EMPTY;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmux_stream_router.sv
// Bench for dmux_stream_router: a cycle table for the 8-channel instance,
// hand sequences for stall, mid-beat reset and the out-of-range drop on a
// 6-channel instance, and a scoreboard checking every channel delivery.
module tb_dmux_stream_router;

  logic       clk;
  logic       rst_n;

  logic       iv8, ir8, bc8, err8;
  logic [7:0] d8, ov8, ordy8, od8;
  logic [2:0] sel8;

  logic       iv6, ir6, bc6, err6;
  logic [7:0] d6, od6;
  logic [5:0] ov6, ordy6;
  logic [2:0] sel6;

  int n_cmp = 0;
  int n_mis = 0;

  dmux_stream_router #(.WIDTH(8), .N(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8), .in_data(d8), .in_sel(sel8), .in_bcast(bc8),
    .out_valid(ov8), .out_ready(ordy8), .out_data(od8), .err_drop(err8)
  );

  dmux_stream_router #(.WIDTH(8), .N(6)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv6), .in_ready(ir6), .in_data(d6), .in_sel(sel6), .in_bcast(bc6),
    .out_valid(ov6), .out_ready(ordy6), .out_data(od6), .err_drop(err6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard of beats expected on the 8-channel instance.
  typedef struct {
    logic [7:0] mask;
    logic [7:0] data;
  } beat_t;

  beat_t      sb[$];
  logic [7:0] acc = '0;
  logic [7:0] mon_fire;

  function automatic logic [7:0] exp_mask(input logic bc, input logic [2:0] sel);
    logic [7:0] one;
    one = 8'h01;
    return bc ? 8'hFF : (one << sel);
  endfunction

  // Every channel handshake must belong to the oldest expected beat.
  always @(negedge clk) begin
    mon_fire = ov8 & ordy8;
    if (rst_n && (mon_fire != 8'h00)) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_handshake", {56'h0, mon_fire}, 64'h0);
      end else begin
        check("sb_data", {56'h0, od8}, {56'h0, sb[0].data});
        check("sb_mask_subset", {56'h0, mon_fire & ~sb[0].mask}, 64'h0);
        acc = acc | mon_fire;
        if ((acc & sb[0].mask) == sb[0].mask) begin
          void'(sb.pop_front());
          acc = '0;
        end
      end
    end
  end

  typedef struct {
    logic       iv;
    logic       bc;
    logic [2:0] sel;
    logic [7:0] d;
    logic [7:0] ordy;
    logic       e_ir;
    logic [7:0] e_ov;
    logic [7:0] e_od;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic iv, input logic bc, input logic [2:0] sel,
                              input logic [7:0] d, input logic [7:0] ordy,
                              input logic e_ir, input logic [7:0] e_ov, input logic [7:0] e_od);
    vec_t v;
    v.iv = iv; v.bc = bc; v.sel = sel; v.d = d; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od;
    return v;
  endfunction

  task automatic drive8(input logic iv, input logic bc, input logic [2:0] sel,
                        input logic [7:0] d, input logic [7:0] ordy);
    iv8 = iv; bc8 = bc; sel8 = sel; d8 = d; ordy8 = ordy;
  endtask

  task automatic drive6(input logic iv, input logic [2:0] sel, input logic [7:0] d);
    iv6 = iv; bc6 = 1'b0; sel6 = sel; d6 = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // unicast sel 5
    vecs[0]  = mk(1, 0, 3'd5, 8'hA5, 8'hFF, 1, 8'h00, 8'h00);
    vecs[1]  = mk(0, 0, 3'd0, 8'h00, 8'hFF, 1, 8'h20, 8'hA5);
    vecs[2]  = mk(0, 0, 3'd0, 8'h00, 8'hFF, 1, 8'h00, 8'h00);
    // broadcast with split acceptance; in_sel ignored
    vecs[3]  = mk(1, 1, 3'd2, 8'h3C, 8'h0F, 1, 8'h00, 8'h00);
    vecs[4]  = mk(0, 0, 3'd0, 8'h00, 8'h0F, 0, 8'hFF, 8'h3C);
    vecs[5]  = mk(0, 0, 3'd0, 8'h00, 8'hF0, 1, 8'hF0, 8'h3C);
    vecs[6]  = mk(0, 0, 3'd0, 8'h00, 8'h00, 1, 8'h00, 8'h00);
    // back-to-back unicast 0,1,2
    vecs[7]  = mk(1, 0, 3'd0, 8'h11, 8'hFF, 1, 8'h00, 8'h00);
    vecs[8]  = mk(1, 0, 3'd1, 8'h22, 8'hFF, 1, 8'h01, 8'h11);
    vecs[9]  = mk(1, 0, 3'd2, 8'h33, 8'hFF, 1, 8'h02, 8'h22);
    vecs[10] = mk(0, 0, 3'd0, 8'h00, 8'hFF, 1, 8'h04, 8'h33);
    // payload fields with in_valid low must be ignored
    vecs[11] = mk(0, 1, 3'd6, 8'hFF, 8'hFF, 1, 8'h00, 8'h00);
    vecs[12] = mk(0, 0, 3'd3, 8'h5A, 8'h00, 1, 8'h00, 8'h00);
    vecs[13] = mk(0, 0, 3'd0, 8'h00, 8'hFF, 1, 8'h00, 8'h00);

    drive8(0, 0, 3'd0, 8'h00, 8'hFF);
    drive6(0, 3'd0, 8'h00);
    ordy6 = 6'h3F;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {56'h0, ov8}, 64'h0);
    check("rst_in_ready", {63'h0, ir8}, 64'h1);
    check("rst_out_data", {56'h0, od8}, 64'h0);
    check("rst_err_drop", {63'h0, err8}, 64'h0);
    check("rst6_out_valid", {58'h0, ov6}, 64'h0);
    check("rst6_err_drop", {63'h0, err6}, 64'h0);

    // Release reset with the first beat already presented: it must be
    // taken on the very first edge.
    next_cycle();
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive8(vecs[i].iv, vecs[i].bc, vecs[i].sel, vecs[i].d, vecs[i].ordy);
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", i), {63'h0, ir8}, {63'h0, vecs[i].e_ir});
      check($sformatf("vec%0d_out_valid", i), {56'h0, ov8}, {56'h0, vecs[i].e_ov});
      if (vecs[i].e_ov != 8'h00)
        check($sformatf("vec%0d_out_data", i), {56'h0, od8}, {56'h0, vecs[i].e_od});
      if (vecs[i].iv && vecs[i].e_ir)
        sb.push_back('{mask: exp_mask(vecs[i].bc, vecs[i].sel), data: vecs[i].d});
      next_cycle();
    end

    // Stalled channel 3 for ten cycles.
    drive8(1, 0, 3'd3, 8'h5A, 8'hF7);
    @(negedge clk);
    check("stall_accept", {63'h0, ir8}, 64'h1);
    sb.push_back('{mask: exp_mask(1'b0, 3'd3), data: 8'h5A});
    next_cycle();
    drive8(0, 0, 3'd0, 8'h00, 8'hF7);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d_out_valid", k), {56'h0, ov8}, 64'h08);
      check($sformatf("stall%0d_out_data", k), {56'h0, od8}, 64'h5A);
      check($sformatf("stall%0d_in_ready", k), {63'h0, ir8}, 64'h0);
      next_cycle();
    end
    ordy8 = 8'hFF;
    @(negedge clk);
    check("stall_release_out_valid", {56'h0, ov8}, 64'h08);
    check("stall_release_in_ready", {63'h0, ir8}, 64'h1);
    next_cycle();
    @(negedge clk);
    check("stall_drained", {56'h0, ov8}, 64'h0);
    next_cycle();

    // Reset while a broadcast still has channels 2 and 3 pending.
    drive8(1, 1, 3'd0, 8'hC3, 8'hF3);
    @(negedge clk);
    check("rbc_accept", {63'h0, ir8}, 64'h1);
    sb.push_back('{mask: 8'hFF, data: 8'hC3});
    next_cycle();
    drive8(0, 0, 3'd0, 8'h00, 8'hF3);
    @(negedge clk);
    check("rbc_first_out_valid", {56'h0, ov8}, 64'hFF);
    check("rbc_first_in_ready", {63'h0, ir8}, 64'h0);
    next_cycle();
    ordy8 = 8'h00;
    @(negedge clk);
    check("rbc_partial_out_valid", {56'h0, ov8}, 64'h0C);
    #1 rst_n = 1'b0;
    #1;
    check("rbc_async_out_valid", {56'h0, ov8}, 64'h0);
    check("rbc_async_in_ready", {63'h0, ir8}, 64'h1);
    check("rbc_async_out_data", {56'h0, od8}, 64'h0);
    sb.delete();
    acc = '0;
    next_cycle();
    @(negedge clk);
    #1 rst_n = 1'b1;
    ordy8 = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rbc_gone%0d", k), {56'h0, ov8}, 64'h0);
    end
    next_cycle();

    // Out-of-range unicast on the 6-channel instance.
    drive6(1, 3'd7, 8'h77);
    @(negedge clk);
    check("oor_in_ready", {63'h0, ir6}, 64'h1);
    check("oor_pre_out_valid", {58'h0, ov6}, 64'h0);
    next_cycle();
    drive6(1, 3'd4, 8'h44);
    @(negedge clk);
    check("oor_err_high", {63'h0, err6}, 64'h1);
    check("oor_out_valid_stays0", {58'h0, ov6}, 64'h0);
    check("oor_next_in_ready", {63'h0, ir6}, 64'h1);
    next_cycle();
    drive6(0, 3'd0, 8'h00);
    @(negedge clk);
    check("oor_err_low", {63'h0, err6}, 64'h0);
    check("oor_next_out_valid", {58'h0, ov6}, 64'h10);
    check("oor_next_out_data", {56'h0, od6}, 64'h44);
    next_cycle();
    @(negedge clk);
    check("oor_drained", {58'h0, ov6}, 64'h0);
    check("oor_err_still_low", {63'h0, err6}, 64'h0);

    check("sb_all_delivered", 64'(sb.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
